// File: rtl/usb_system_sysid_pkg.sv
// Shared types and constants for the system-ID checker: FSM states,
// sysid slave word addresses and the data width.
package usb_system_sysid_pkg;

    localparam int unsigned SYSID_DATA_W  = 32;
    localparam logic        SYSID_ADDR_ID = 1'b0;
    localparam logic        SYSID_ADDR_TS = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        DONE  = 2'd3
    } sysid_state_e;

    // Full-width equality of both captured words against the build-time values.
    function automatic logic sysid_words_match(
        input logic [SYSID_DATA_W-1:0] id_word,
        input logic [SYSID_DATA_W-1:0] ts_word,
        input logic [SYSID_DATA_W-1:0] exp_id,
        input logic [SYSID_DATA_W-1:0] exp_ts
    );
        return (id_word == exp_id) && (ts_word == exp_ts);
    endfunction

endpackage

// File: rtl/usb_system_sysid_timeout_ctr.sv
// Stall counter for one Avalon read: cleared by clr, advanced by en,
// expire_c flags the stalled cycle that reaches TIMEOUT_CYCLES.
module usb_system_sysid_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // cnt_q stalled cycles have already elapsed, so this one is the last allowed.
    assign expire_c = en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_system_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and
// checks them against build-time values. SYSID_CHECK_RETRY_EN adds retries.
module usb_system_sysid_checker
    import usb_system_sysid_pkg::*;
#(
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_ID        = 32'd0,
    parameter logic [SYSID_DATA_W-1:0] EXPECTED_TIMESTAMP = 32'd1430957044,
    parameter int unsigned             TIMEOUT_CYCLES     = 256,
    parameter int unsigned             MAX_RETRIES        = 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    output logic                    avm_address,
    output logic                    avm_read,
    input  logic [SYSID_DATA_W-1:0] avm_readdata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic [SYSID_DATA_W-1:0] id_value,
    output logic [SYSID_DATA_W-1:0] ts_value
);

    sysid_state_e            state_q, state_d;
    logic                    avm_read_q, avm_read_d;
    logic                    avm_address_q, avm_address_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic [SYSID_DATA_W-1:0] id_value_q, id_value_d;
    logic [SYSID_DATA_W-1:0] ts_value_q, ts_value_d;

    logic in_read_c;
    logic stall_c;
    logic tmo_clr_c;
    logic tmo_expire_c;
    logic attempt_end_c;
    logic attempt_ok_c;

`ifdef SYSID_CHECK_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    logic [RTY_W-1:0] retry_cnt_q, retry_cnt_d;
    logic             retry_go_q, retry_go_d;
`else
    // Single-attempt build: the retry limit has no logic behind it.
    logic unused_max_retries_c;
    assign unused_max_retries_c = ^MAX_RETRIES;
`endif

    assign in_read_c = (state_q == RD_ID) || (state_q == RD_TS);
    assign stall_c   = in_read_c && avm_waitrequest;
    assign tmo_clr_c = !stall_c;

    usb_system_sysid_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (tmo_clr_c),
        .en      (stall_c),
        .expire_c(tmo_expire_c)
    );

    always_comb begin
        state_d       = state_q;
        avm_read_d    = avm_read_q;
        avm_address_d = avm_address_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        pass_d        = pass_q;
        timeout_d     = timeout_q;
        id_value_d    = id_value_q;
        ts_value_d    = ts_value_q;
        attempt_end_c = 1'b0;
        attempt_ok_c  = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        retry_cnt_d   = retry_cnt_q;
        retry_go_d    = retry_go_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = RD_ID;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_ID;
                    busy_d        = 1'b1;
                    pass_d        = 1'b0;
                    timeout_d     = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_cnt_d   = '0;
                    retry_go_d    = 1'b0;
`endif
                end
            end
            RD_ID: begin
                if (!avm_waitrequest) begin
                    id_value_d    = avm_readdata;
                    avm_address_d = SYSID_ADDR_TS;
                    state_d       = RD_TS;
                end else if (tmo_expire_c) begin
                    timeout_d     = 1'b1;
                    attempt_end_c = 1'b1;
                end
            end
            RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_value_d    = avm_readdata;
                    attempt_end_c = 1'b1;
                    attempt_ok_c  = sysid_words_match(id_value_q, avm_readdata,
                                                      EXPECTED_ID, EXPECTED_TIMESTAMP);
                end else if (tmo_expire_c) begin
                    timeout_d     = 1'b1;
                    attempt_end_c = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
                if (retry_go_q) begin
                    state_d       = RD_ID;
                    busy_d        = 1'b1;
                    avm_read_d    = 1'b1;
                    avm_address_d = SYSID_ADDR_ID;
                    retry_cnt_d   = retry_cnt_q + RTY_W'(1);
                    retry_go_d    = 1'b0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Common exit from either read: the verdict is latched on entry to DONE.
        if (attempt_end_c) begin
            state_d       = DONE;
            avm_read_d    = 1'b0;
            avm_address_d = SYSID_ADDR_ID;
            pass_d        = attempt_ok_c;
            done_d        = 1'b1;
`ifdef SYSID_CHECK_RETRY_EN
            // pass reflects the final attempt; timeout stays sticky across retries.
            if (!attempt_ok_c && (retry_cnt_q < RTY_W'(MAX_RETRIES))) begin
                retry_go_d = 1'b1;
                pass_d     = 1'b0;
                done_d     = 1'b0;
            end else begin
                retry_go_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            avm_read_q    <= 1'b0;
            avm_address_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            id_value_q    <= '0;
            ts_value_q    <= '0;
        end else begin
            state_q       <= state_d;
            avm_read_q    <= avm_read_d;
            avm_address_q <= avm_address_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            timeout_q     <= timeout_d;
            id_value_q    <= id_value_d;
            ts_value_q    <= ts_value_d;
        end
    end

`ifdef SYSID_CHECK_RETRY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retry_cnt_q <= '0;
            retry_go_q  <= 1'b0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            retry_go_q  <= retry_go_d;
        end
    end
`endif

    assign avm_read    = avm_read_q;
    assign avm_address = avm_address_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign id_value    = id_value_q;
    assign ts_value    = ts_value_q;

endmodule
